// File: rtl/gen_paridad_dut.sv
// gen_paridad_dut: registered 7-bit parity generator with optional rx checker (GEN_PARIDAD_CHECK_EN)
module gen_paridad_dut (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] data,
  input  logic       parimpar,
  input  logic       valid_in,
  output logic       paridad,
  output logic [7:0] frame_out,
  output logic       valid_out,
  input  logic [7:0] rx_frame,
  input  logic       rx_valid,
  input  logic       err_clr,
  output logic       err,
  output logic [7:0] err_count
);
  logic par_next;
  assign par_next = ^data ^ parimpar;
  // Load parity and frame on accepted samples; hold otherwise
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      paridad   <= 1'b0;
      frame_out <= 8'h00;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        paridad   <= par_next;
        frame_out <= {par_next, data};
      end
    end
`ifdef GEN_PARIDAD_CHECK_EN
  logic rx_fail;
  assign rx_fail = rx_valid & (^rx_frame ^ parimpar);
  // Pulse err on failing frames; count saturates at 255 and clear beats increment
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err       <= 1'b0;
      err_count <= 8'h00;
    end else begin
      err       <= rx_fail;
      err_count <= err_clr ? 8'h00 : (rx_fail && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
`else
  logic unused_rx;
  assign unused_rx = ^{rx_frame, rx_valid, err_clr};
  assign err       = 1'b0;
  assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_gen_paridad_dut.sv
// tb_gen_paridad_dut: directed self-checking bench for gen_paridad_dut
module tb_gen_paridad_dut;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] data;
  logic       parimpar;
  logic       valid_in;
  logic       paridad;
  logic [7:0] frame_out;
  logic       valid_out;
  logic [7:0] rx_frame;
  logic       rx_valid;
  logic       err_clr;
  logic       err;
  logic [7:0] err_count;
  int errs = 0;
  int checks = 0;

  gen_paridad_dut dut (
    .clk(clk), .reset(reset), .data(data), .parimpar(parimpar), .valid_in(valid_in),
    .paridad(paridad), .frame_out(frame_out), .valid_out(valid_out),
    .rx_frame(rx_frame), .rx_valid(rx_valid), .err_clr(err_clr),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gen(input string tag, input logic p, input logic [7:0] f, input logic v);
    chk({tag, ".paridad"}, {31'd0, paridad}, {31'd0, p});
    chk({tag, ".frame"}, {24'd0, frame_out}, {24'd0, f});
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
  endtask

  task automatic chk_rx(input string tag, input logic e, input logic [7:0] c);
    chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
    chk({tag, ".count"}, {24'd0, err_count}, {24'd0, c});
  endtask

  initial begin
    reset = 1'b1; data = 7'h00; parimpar = 1'b0; valid_in = 1'b0;
    rx_frame = 8'h00; rx_valid = 1'b0; err_clr = 1'b0;
    #1;
    chk_gen("reset_async", 1'b0, 8'h00, 1'b0);
    chk_rx("reset_async", 1'b0, 8'h00);
    #11;
    chk_gen("reset", 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    data = 7'h00; parimpar = 1'b0; valid_in = 1'b1;
    cyc();
    chk_gen("zero_even", 1'b0, 8'h00, 1'b1);
    parimpar = 1'b1;
    cyc();
    chk_gen("zero_odd", 1'b1, 8'h80, 1'b1);
    data = 7'h7F; parimpar = 1'b0;
    cyc();
    chk_gen("ones_even", 1'b1, 8'hFF, 1'b1);
    parimpar = 1'b1;
    cyc();
    chk_gen("ones_odd", 1'b0, 8'h7F, 1'b1);
    data = 7'h55; parimpar = 1'b0;
    cyc();
    chk_gen("h55_even", 1'b0, 8'h55, 1'b1);
    valid_in = 1'b0; data = 7'h01; parimpar = 1'b1;
    cyc();
    chk_gen("hold1", 1'b0, 8'h55, 1'b0);
    cyc();
    chk_gen("hold2", 1'b0, 8'h55, 1'b0);
    valid_in = 1'b1;
    for (int m = 0; m < 2; m++)
      for (int d = 0; d < 128; d++) begin
        parimpar = m[0];
        data = d[6:0];
        cyc();
        chk("sweep.par", {31'd0, frame_out[7]}, {31'd0, 1'($countones(d[6:0]) % 2) ^ m[0]});
        chk("sweep.ones", $countones(frame_out) % 2, m);
        chk("sweep.data", {25'd0, frame_out[6:0]}, d);
        chk("sweep.valid", {31'd0, valid_out}, 32'd1);
      end
    valid_in = 1'b0;
    parimpar = 1'b0;
    rx_valid = 1'b1; rx_frame = 8'hFF;
    cyc();
`ifdef GEN_PARIDAD_CHECK_EN
    chk_rx("rx_ff_even", 1'b0, 8'd0);
    rx_frame = 8'h01;
    cyc();
    chk_rx("rx_01_even", 1'b1, 8'd1);
    rx_valid = 1'b0;
    cyc();
    chk_rx("rx_pulse_end", 1'b0, 8'd1);
    rx_valid = 1'b1; err_clr = 1'b1;
    cyc();
    chk_rx("clr_wins", 1'b1, 8'd0);
    err_clr = 1'b0; parimpar = 1'b1; rx_frame = 8'h00;
    cyc();
    chk_rx("rx_00_odd", 1'b1, 8'd1);
    rx_frame = 8'h01;
    cyc();
    chk_rx("rx_01_odd", 1'b0, 8'd1);
    parimpar = 1'b0; rx_frame = 8'h03; err_clr = 1'b1; rx_valid = 1'b0;
    cyc();
    err_clr = 1'b0; rx_valid = 1'b1; rx_frame = 8'h07;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (i == 254) chk_rx("sat_reach", 1'b1, 8'd255);
    end
    chk_rx("sat_hold", 1'b1, 8'd255);
    rx_valid = 1'b0; err_clr = 1'b1;
    cyc();
    chk_rx("sat_clr", 1'b0, 8'd0);
    err_clr = 1'b0; rx_valid = 1'b1; rx_frame = 8'h01;
    repeat (4) cyc();
    valid_in = 1'b1; data = 7'h0F;
    cyc();
    chk_gen("pre_reset", 1'b0, 8'h0F, 1'b1);
    chk_rx("pre_reset", 1'b1, 8'd5);
`else
    chk_rx("rx_off", 1'b0, 8'd0);
    rx_frame = 8'h01; err_clr = 1'b0;
    repeat (4) cyc();
    chk_rx("rx_off_fail", 1'b0, 8'd0);
    valid_in = 1'b1; data = 7'h0F;
    cyc();
    chk_gen("pre_reset", 1'b0, 8'h0F, 1'b1);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk_gen("mid_reset", 1'b0, 8'h00, 1'b0);
    chk_rx("mid_reset", 1'b0, 8'd0);
    #1;
    reset = 1'b0;
    rx_valid = 1'b0; valid_in = 1'b1; data = 7'h03; parimpar = 1'b1;
    cyc();
    chk_gen("post_reset", 1'b1, 8'h83, 1'b1);
    chk_rx("post_reset", 1'b0, 8'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/gen_paridad_dut.md
# gen_paridad_dut

Registered 7-bit parity generator with selectable even/odd parity and an optional receive-side parity checker. It produces the parity bit and an 8-bit frame, {parity, data}, for a downstream serializer or link. The compiled-in checker validates incoming 8-bit frames and keeps a saturating error count. The block sits between the data source and the physical-layer framing logic.

## Interface
- No parameters. Data width is fixed at 7; frame width is fixed at 8.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset; one clock domain only.
- data  input  7  payload to protect.
- parimpar  input  1  parity mode: 0 = even, 1 = odd. Shared by generator and checker.
- valid_in  input  1  data/parimpar are sampled when high.
- paridad  output  1  registered parity bit of the last accepted sample.
- frame_out  output  8  registered {paridad, data}; bit 7 is parity.
- valid_out  output  1  one-cycle pulse per accepted sample.
- rx_frame  input  8  received frame {parity, data} (checker only).
- rx_valid  input  1  rx_frame is sampled when high (checker only).
- err_clr  input  1  synchronous clear of err_count (checker only).
- err  output  1  registered one-cycle pulse when a checked frame fails parity.
- err_count  output  8  saturating count of failed frames.

## Operation
- Even mode (parimpar=0): paridad = XOR of data[6:0]. Total ones in frame_out are then even.
- Odd mode (parimpar=1): paridad = XNOR of data[6:0]. Total ones in frame_out are then odd.
- Sampled cycle (valid_in=1): paridad, frame_out and valid_out=1 are loaded.
- Idle cycle (valid_in=0): paridad and frame_out hold their values; valid_out=0.
- A mode change takes effect only on the next accepted sample. Already-registered outputs are never recomputed.
- Checker, even mode: a frame fails when the XOR of all 8 rx_frame bits is 1.
- Checker, odd mode: a frame fails when the XOR of all 8 rx_frame bits is 0.
- On a failing rx_valid cycle: err=1 for one cycle, and err_count increments.
- err_count saturates at 255; further failures leave it at 255 but still pulse err.
- err_clr=1 sets err_count to 0 at the next edge. When err_clr coincides with a failure, clear wins: count=0, but err still pulses.
- Generator and checker are independent. valid_in and rx_valid may be active in the same cycle.

## Timing
- Generator latency: exactly 1 cycle, from the valid_in edge to paridad/frame_out/valid_out.
- Back-to-back samples are accepted every cycle; throughput is 1 sample per clock.
- Checker latency: 1 cycle, from the rx_valid edge to err and the err_count update.
- Reset values: paridad=0, frame_out=8'h00, valid_out=0, err=0, err_count=0.
- Reset asserted mid-stream clears all outputs immediately, without waiting for clk.
- The first sample after reset deassertion is accepted on the first rising edge with valid_in=1.
- No combinational path from any input to any output.

## Configuration
- Macro: GEN_PARIDAD_CHECK_EN.
- Defined: the checker is compiled in, with the behaviour described above.
- Undefined: the checker logic is removed. rx_frame, rx_valid and err_clr are ignored. err is tied to 0 and err_count to 8'h00. Generator behaviour is identical in both builds.

## Test plan
- Zero payload: data=7'h00, valid_in=1. With parimpar=0 -> next cycle paridad=0, frame_out=8'h00, valid_out=1. With parimpar=1 -> paridad=1, frame_out=8'h80.
- All-ones payload: data=7'h7F. With parimpar=0 -> paridad=1, frame_out=8'hFF. With parimpar=1 -> paridad=0, frame_out=8'h7F.
- Hold and sweep: data=7'h55, parimpar=0 -> paridad=0. Drop valid_in and change data to 7'h01 -> outputs hold and valid_out=0. Then sweep all 128 data values in both modes -> popcount(frame_out) parity matches the mode for every value.
- Checker, even mode: rx_frame=8'hFF -> err=0. rx_frame=8'h01 -> err=1 for one cycle and err_count=1. err_clr plus failure in the same cycle -> err_count=0 and err=1.
- Saturation: 300 consecutive failing frames -> err_count=255 and stays there. Then err_clr -> 0.
- Reset mid-operation: assert reset between edges while valid_out=1 and err_count=5 -> all outputs 0 immediately. After release, the first sample gives correct parity after 1 cycle.
